// File: rtl/lcd_ctrl_pkg.sv
// Shared types and constants for the LCD image-processing controller.
// Optional feature macro LCD_CTRL_MIRROR_EN enables the mirror commands 10/11.
package lcd_ctrl_pkg;

   localparam int unsigned IMG_DIM   = 8;
   localparam int unsigned PIX_NUM   = IMG_DIM * IMG_DIM;
   localparam logic [5:0]  LAST_ADDR = 6'd63;
   localparam logic [2:0]  INIT_X    = 3'd4;
   localparam logic [2:0]  INIT_Y    = 3'd4;
   localparam logic [2:0]  POS_MIN   = 3'd1;
   localparam logic [2:0]  POS_MAX   = 3'd7;

   typedef enum logic [3:0] {
      CMD_WRITE = 4'd0,
      CMD_UP    = 4'd1,
      CMD_DOWN  = 4'd2,
      CMD_LEFT  = 4'd3,
      CMD_RIGHT = 4'd4,
      CMD_MAX   = 4'd5,
      CMD_MIN   = 4'd6,
      CMD_AVG   = 4'd7,
      CMD_CCW   = 4'd8,
      CMD_CW    = 4'd9,
      CMD_MIRX  = 4'd10,
      CMD_MIRY  = 4'd11
   } cmd_e;

   typedef enum logic [2:0] {
      ST_LOAD,
      ST_IDLE,
      ST_EXEC,
      ST_WRITE,
      ST_DONE
   } state_e;

endpackage

// File: rtl/lcd_blk_alu.sv
// Combinational 2x2 block operator: new TL/TR/BL/BR values for a command.
// Mirror commands 10/11 are only decoded when LCD_CTRL_MIRROR_EN is defined.
module lcd_blk_alu
   import lcd_ctrl_pkg::*;
(
   input  logic [3:0] cmd,
   input  logic [7:0] tl,
   input  logic [7:0] tr,
   input  logic [7:0] bl,
   input  logic [7:0] br,
   output logic [7:0] n_tl,
   output logic [7:0] n_tr,
   output logic [7:0] n_bl,
   output logic [7:0] n_br
);

   logic [9:0] sum;
   logic [7:0] mx, mn;

   always_comb begin
      sum = {2'b00, tl} + {2'b00, tr} + {2'b00, bl} + {2'b00, br};
      mx  = tl;
      mn  = tl;
      if (tr > mx) mx = tr;
      if (bl > mx) mx = bl;
      if (br > mx) mx = br;
      if (tr < mn) mn = tr;
      if (bl < mn) mn = bl;
      if (br < mn) mn = br;
   end

   always_comb begin
      n_tl = tl;
      n_tr = tr;
      n_bl = bl;
      n_br = br;
      case (cmd)
         CMD_MAX: begin n_tl = mx; n_tr = mx; n_bl = mx; n_br = mx; end
         CMD_MIN: begin n_tl = mn; n_tr = mn; n_bl = mn; n_br = mn; end
         CMD_AVG: begin
            n_tl = sum[9:2]; n_tr = sum[9:2]; n_bl = sum[9:2]; n_br = sum[9:2];
         end
         CMD_CCW: begin n_tl = tr; n_tr = br; n_br = bl; n_bl = tl; end
         CMD_CW:  begin n_tl = bl; n_tr = tl; n_br = tr; n_bl = br; end
`ifdef LCD_CTRL_MIRROR_EN
         CMD_MIRX: begin n_tl = bl; n_bl = tl; n_tr = br; n_br = tr; end
         CMD_MIRY: begin n_tl = tr; n_tr = tl; n_bl = br; n_br = bl; end
`endif
         default: ;
      endcase
   end

endmodule

// File: rtl/lcd_ctrl.sv
// LCD controller: loads an 8x8 image from ROM, applies block commands, writes it to RAM.
// Optional feature macro LCD_CTRL_MIRROR_EN enables the mirror commands 10/11.
module lcd_ctrl
   import lcd_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] cmd,
   input  logic       cmd_valid,
   output logic       IROM_rd,
   output logic [5:0] IROM_A,
   input  logic [7:0] IROM_Q,
   output logic       IRAM_valid,
   output logic [5:0] IRAM_A,
   output logic [7:0] IRAM_D,
   output logic       busy,
   output logic       done
);

   state_e     state, state_nxt;
   logic [7:0] pix [PIX_NUM];
   logic [2:0] x, y;
   logic [3:0] cmd_q;
   logic       pend;
   logic [5:0] pend_addr;
   logic [5:0] a_tl, a_tr, a_bl, a_br;
   logic [7:0] n_tl, n_tr, n_bl, n_br;
   logic       load_last, wr_last;

   assign a_tl = {y - 3'd1, x - 3'd1};
   assign a_tr = {y - 3'd1, x};
   assign a_bl = {y, x - 3'd1};
   assign a_br = {y, x};

   assign load_last = pend && (pend_addr == LAST_ADDR);
   assign wr_last   = (IRAM_A == LAST_ADDR);
   assign busy      = (state != ST_IDLE);
   assign done      = (state == ST_DONE);

   lcd_blk_alu u_alu (
      .cmd  (cmd_q),
      .tl   (pix[a_tl]),
      .tr   (pix[a_tr]),
      .bl   (pix[a_bl]),
      .br   (pix[a_br]),
      .n_tl (n_tl),
      .n_tr (n_tr),
      .n_bl (n_bl),
      .n_br (n_br)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= ST_LOAD;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_LOAD:  if (load_last) state_nxt = ST_IDLE;
         ST_IDLE:  if (cmd_valid) state_nxt = (cmd == CMD_WRITE) ? ST_WRITE : ST_EXEC;
         ST_EXEC:  state_nxt = ST_IDLE;
         ST_WRITE: if (wr_last) state_nxt = ST_DONE;
         ST_DONE:  state_nxt = ST_DONE;
         default:  state_nxt = ST_LOAD;
      endcase
   end

   // ROM data lags its address by one cycle, so the captured address rides along in pend_addr.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         IROM_rd    <= 1'b0;
         IROM_A     <= '0;
         pend       <= 1'b0;
         pend_addr  <= '0;
         x          <= INIT_X;
         y          <= INIT_Y;
         cmd_q      <= '0;
         IRAM_valid <= 1'b0;
         IRAM_A     <= '0;
         IRAM_D     <= '0;
      end else begin
         case (state)
            ST_LOAD: begin
               pend      <= IROM_rd;
               pend_addr <= IROM_A;
               if (IROM_rd) begin
                  if (IROM_A == LAST_ADDR) IROM_rd <= 1'b0;
                  else                     IROM_A  <= IROM_A + 6'd1;
               end else if (!pend) begin
                  IROM_rd <= 1'b1;
                  IROM_A  <= '0;
               end
            end
            ST_IDLE: begin
               if (cmd_valid) begin
                  cmd_q <= cmd;
                  if (cmd == CMD_WRITE) begin
                     IRAM_valid <= 1'b1;
                     IRAM_A     <= '0;
                     IRAM_D     <= pix[0];
                  end
               end
            end
            ST_EXEC: begin
               case (cmd_q)
                  CMD_UP:    if (y > POS_MIN) y <= y - 3'd1;
                  CMD_DOWN:  if (y < POS_MAX) y <= y + 3'd1;
                  CMD_LEFT:  if (x > POS_MIN) x <= x - 3'd1;
                  CMD_RIGHT: if (x < POS_MAX) x <= x + 3'd1;
                  default: ;
               endcase
            end
            ST_WRITE: begin
               if (wr_last) begin
                  IRAM_valid <= 1'b0;
               end else begin
                  IRAM_A <= IRAM_A + 6'd1;
                  IRAM_D <= pix[IRAM_A + 6'd1];
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (state == ST_LOAD && pend) begin
         pix[pend_addr] <= IROM_Q;
      end else if (state == ST_EXEC) begin
         pix[a_tl] <= n_tl;
         pix[a_tr] <= n_tr;
         pix[a_bl] <= n_bl;
         pix[a_br] <= n_br;
      end
   end

endmodule

// File: tb/tb_lcd_ctrl.sv
// Directed scoreboard bench for lcd_ctrl; ROM image is pixel[i] = i.
// Expectations follow LCD_CTRL_MIRROR_EN when the bench is built with it defined.
module tb_lcd_ctrl;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] cmd = '0;
   logic       cmd_valid = 1'b0;
   logic       IROM_rd;
   logic [5:0] IROM_A;
   logic [7:0] IROM_Q = '0;
   logic       IRAM_valid;
   logic [5:0] IRAM_A;
   logic [7:0] IRAM_D;
   logic       busy, done;

   typedef struct { logic [5:0] a; logic [7:0] d; } wr_t;
   wr_t exp_q[$];

   int checks = 0;
   int failures = 0;
   int rom_exp = 0;
   int wr_cnt = 0;
   int img [64];
   int px, py;
   int ram [64];

   lcd_ctrl dut (
      .clk        (clk),
      .reset      (reset),
      .cmd        (cmd),
      .cmd_valid  (cmd_valid),
      .IROM_rd    (IROM_rd),
      .IROM_A     (IROM_A),
      .IROM_Q     (IROM_Q),
      .IRAM_valid (IRAM_valid),
      .IRAM_A     (IRAM_A),
      .IRAM_D     (IRAM_D),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (IROM_rd) IROM_Q <= {2'b00, IROM_A};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: got %0d want %0d", tag, obs, exp);
      end
   endtask

   // ROM address sequence and RAM write scoreboard
   always @(negedge clk) begin
      if (IROM_rd) begin
         chk("rom_addr", 32'(IROM_A), 32'(rom_exp));
         rom_exp++;
      end
      if (IRAM_valid) begin
         chk("wr_expected", 32'(exp_q.size() > 0), 32'd1);
         if (exp_q.size() > 0) begin
            wr_t e;
            e = exp_q.pop_front();
            chk("wr_addr", 32'(IRAM_A), 32'(e.a));
            chk("wr_data", 32'(IRAM_D), 32'(e.d));
         end
         ram[IRAM_A] = int'(IRAM_D);
         wr_cnt++;
      end
   end

   function automatic void model_init();
      for (int i = 0; i < 64; i++) img[i] = i;
      px = 4;
      py = 4;
   endfunction

   function automatic void model_apply(input int c);
      int tl, tr, bl, br, vtl, vtr, vbl, vbr, m;
      tl = (py - 1) * 8 + px - 1;
      tr = tl + 1;
      bl = py * 8 + px - 1;
      br = bl + 1;
      vtl = img[tl]; vtr = img[tr]; vbl = img[bl]; vbr = img[br];
      case (c)
         1: if (py > 1) py--;
         2: if (py < 7) py++;
         3: if (px > 1) px--;
         4: if (px < 7) px++;
         5, 6: begin
            m = vtl;
            foreach (img[k]) if (k == tr || k == bl || k == br)
               if ((c == 5) ? (img[k] > m) : (img[k] < m)) m = img[k];
            img[tl] = m; img[tr] = m; img[bl] = m; img[br] = m;
         end
         7: begin
            m = (vtl + vtr + vbl + vbr) / 4;
            img[tl] = m; img[tr] = m; img[bl] = m; img[br] = m;
         end
         8: begin img[tl] = vtr; img[tr] = vbr; img[br] = vbl; img[bl] = vtl; end
         9: begin img[tl] = vbl; img[tr] = vtl; img[br] = vtr; img[bl] = vbr; end
`ifdef LCD_CTRL_MIRROR_EN
         10: begin img[tl] = vbl; img[bl] = vtl; img[tr] = vbr; img[br] = vtr; end
         11: begin img[tl] = vtr; img[tr] = vtl; img[bl] = vbr; img[br] = vbl; end
`endif
         default: ;
      endcase
   endfunction

   task automatic wait_ready();
      int n = 0;
      while (busy !== 1'b0 && n < 300) begin @(negedge clk); n++; end
      chk("ready", 32'(busy), 32'd0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      #2 reset = 1'b0;
      cmd_valid = 1'b0;
      #1;
      exp_q.delete();
      chk("rst_busy", 32'(busy), 32'd1);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_rom_rd", 32'(IROM_rd), 32'd0);
      chk("rst_rom_a", 32'(IROM_A), 32'd0);
      chk("rst_ram_v", 32'(IRAM_valid), 32'd0);
      chk("rst_ram_a", 32'(IRAM_A), 32'd0);
      chk("rst_ram_d", 32'(IRAM_D), 32'd0);
      rom_exp = 0;
      @(negedge clk);
      reset = 1'b1;
      model_init();
      wait_ready();
      chk("load_count", 32'(rom_exp), 32'd64);
      chk("load_rom_rd", 32'(IROM_rd), 32'd0);
   endtask

   task automatic send(input logic [3:0] c);
      wait_ready();
      cmd = c;
      cmd_valid = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
      cmd = 4'($urandom);
      chk("busy_accept", 32'(busy), 32'd1);
      if (c != 4'd0) begin
         model_apply(int'(c));
         @(negedge clk);
         chk("busy_return", 32'(busy), 32'd0);
      end
   endtask

   task automatic start_write();
      wr_t e;
      wr_cnt = 0;
      for (int i = 0; i < 64; i++) begin
         e.a = 6'(i);
         e.d = 8'(img[i]);
         exp_q.push_back(e);
      end
      send(4'd0);
   endtask

   task automatic write_all();
      int n = 0;
      start_write();
      while (done !== 1'b1 && n < 200) begin @(negedge clk); n++; end
      chk("done", 32'(done), 32'd1);
      chk("done_busy", 32'(busy), 32'd1);
      chk("wr_count", 32'(wr_cnt), 32'd64);
      chk("queue_empty", 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      // Max on fresh image, then commands ignored after done
      do_reset();
      send(4'd5);
      write_all();
      chk("max_27", 32'(ram[27]), 32'd36);
      chk("max_28", 32'(ram[28]), 32'd36);
      chk("max_35", 32'(ram[35]), 32'd36);
      chk("max_36", 32'(ram[36]), 32'd36);
      chk("max_0", 32'(ram[0]), 32'd0);
      chk("max_63", 32'(ram[63]), 32'd63);
      cmd = 4'd0;
      cmd_valid = 1'b1;
      repeat (4) @(negedge clk);
      cmd_valid = 1'b0;
      chk("hold_done", 32'(done), 32'd1);
      chk("hold_busy", 32'(busy), 32'd1);
      chk("hold_nowr", 32'(wr_cnt), 32'd64);

      do_reset();
      send(4'd6);
      write_all();
      chk("min_27", 32'(ram[27]), 32'd27);
      chk("min_36", 32'(ram[36]), 32'd27);

      do_reset();
      send(4'd7);
      write_all();
      chk("avg_28", 32'(ram[28]), 32'd31);
      chk("avg_35", 32'(ram[35]), 32'd31);

      do_reset();
      send(4'd9);
      write_all();
      chk("cw_27", 32'(ram[27]), 32'd35);
      chk("cw_28", 32'(ram[28]), 32'd27);
      chk("cw_35", 32'(ram[35]), 32'd36);
      chk("cw_36", 32'(ram[36]), 32'd28);

      do_reset();
      send(4'd9);
      send(4'd8);
      write_all();
      chk("ccw_27", 32'(ram[27]), 32'd27);
      chk("ccw_36", 32'(ram[36]), 32'd36);

      // Move to the left edge, then down past the bottom edge
      do_reset();
      repeat (5) send(4'd3);
      send(4'd5);
      repeat (5) send(4'd2);
      send(4'd6);
      write_all();
      chk("mv_24", 32'(ram[24]), 32'd33);
      chk("mv_32", 32'(ram[32]), 32'd33);
      chk("sat_49", 32'(ram[49]), 32'd48);
      chk("sat_57", 32'(ram[57]), 32'd48);

      do_reset();
      send(4'd10);
      write_all();
`ifdef LCD_CTRL_MIRROR_EN
      chk("mir_27", 32'(ram[27]), 32'd35);
      chk("mir_35", 32'(ram[35]), 32'd27);
      chk("mir_28", 32'(ram[28]), 32'd36);
      chk("mir_36", 32'(ram[36]), 32'd28);
`else
      chk("mir_27", 32'(ram[27]), 32'd27);
      chk("mir_35", 32'(ram[35]), 32'd35);
      chk("mir_28", 32'(ram[28]), 32'd28);
      chk("mir_36", 32'(ram[36]), 32'd36);
`endif

      // Reset in the middle of a write, then a no-op and a clean write
      do_reset();
      start_write();
      repeat (10) @(negedge clk);
      do_reset();
      begin
         int wr_before;
         wr_before = wr_cnt;
         repeat (80) @(negedge clk);
         chk("abort_nowr", 32'(wr_cnt), 32'(wr_before));
         chk("abort_done", 32'(done), 32'd0);
      end
      send(4'd12);
      write_all();
      chk("noop_27", 32'(ram[27]), 32'd27);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
